// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, owner} of each read grant for RD_LAT cycles
// so returning memory data can be steered to the requester that issued it.
module rd_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t push_i,
  output rd_tag_t tail_o,
  output logic    m0_pend_o
);

  rd_tag_t stage_q [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push_i;
      for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Any core read still travelling, including the one returning this cycle.
  always_comb begin
    m0_pend_o = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (stage_q[i].valid && stage_q[i].owner == OWNER_M0) m0_pend_o = 1'b1;
    end
  end

  assign tail_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the core (m0)
// and the loader/DMA (m1), with bounded m1 bursts and owner-tagged read return.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LAT     = 1,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WIDTH-1:0]      m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [WIDTH-1:0]      m0_rdata_o,
  output logic                  core_stall_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WIDTH-1:0]      m1_wdata_i,
  input  logic                  m1_lock_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [WIDTH-1:0]      m1_rdata_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       gnt0, gnt1;
  rd_tag_t    push, tail;
  logic       m0_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWNER_M1;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    state_d      = state_q;
    last_owner_d = last_owner_q;
    lock_cnt_d   = lock_cnt_q;

    if (m0_req_i && m1_req_i) begin
      // A locked m1 burst may continue until it has held m0 off BURST_MAX times.
      if (state_q == ARB_OWN1 && m1_lock_i && lock_cnt_q < BURST_LIM) gnt1 = 1'b1;
      else if (last_owner_q == OWNER_M1)                               gnt0 = 1'b1;
      else                                                             gnt1 = 1'b1;
    end else begin
      gnt0 = m0_req_i;
      gnt1 = m1_req_i;
    end

    if (!rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) begin
      state_d      = ARB_OWN0;
      last_owner_d = OWNER_M0;
    end else if (gnt1) begin
      state_d      = ARB_OWN1;
      last_owner_d = OWNER_M1;
    end else begin
      state_d      = ARB_IDLE;
    end

    if (gnt0 || !m1_lock_i)    lock_cnt_d = '0;
    else if (gnt1 && m0_req_i) lock_cnt_d = lock_cnt_q + 4'd1;
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign mem_read_o  = (gnt0 & ~m0_we_i) | (gnt1 & ~m1_we_i);
  assign mem_write_o = (gnt0 & m0_we_i) | (gnt1 & m1_we_i);
  assign mem_addr_o  = gnt0 ? m0_addr_i  : (gnt1 ? m1_addr_i  : '0);
  assign mem_wdata_o = gnt0 ? m0_wdata_i : (gnt1 ? m1_wdata_i : '0);

  assign push.valid = mem_read_o;
  assign push.owner = gnt1 ? OWNER_M1 : OWNER_M0;

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .tail_o    (tail),
    .m0_pend_o (m0_pend)
  );

  assign m0_rvalid_o  = tail.valid && (tail.owner == OWNER_M0);
  assign m1_rvalid_o  = tail.valid && (tail.owner == OWNER_M1);
  assign m0_rdata_o   = mem_rdata_i;
  assign m1_rdata_o   = mem_rdata_i;
  assign core_stall_o = rst & ((m0_req_i & ~gnt0) | (m0_pend & ~m0_rvalid_o));

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous memory port between two requesters.
- Requester 0 is the multicycle core (memread/memwrite/memaddr/memwdata). Requester 1 is the program loader / DMA engine.
- Performs round-robin arbitration with a bounded lock for requester-1 bursts, and tags in-flight reads so read data returns to the correct owner.
- Drives a stall to the core whenever the core's access is not yet granted, or its read data has not yet returned.

Parameters:
- WIDTH, 32 (`WIDTH`): data width.
- ADDR_WIDTH, 32 (`ADDR_WIDTH`): address width.
- RD_LAT, 1: memory read latency in cycles, from command to mem_rdata_i valid; legal range 1..3.
- BURST_MAX, 4: maximum consecutive grants to m1 while m1_lock_i is high and m0 is waiting; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0_req_i  in  1  core access request.
- m0_we_i  in  1  1 = write, 0 = read.
- m0_addr_i  in  ADDR_WIDTH  core address.
- m0_wdata_i  in  WIDTH  core write data.
- m0_gnt_o  out  1  core access accepted this cycle.
- m0_rvalid_o  out  1  m0_rdata_o valid this cycle.
- m0_rdata_o  out  WIDTH  read data to core.
- core_stall_o  out  1  hold core FSM/PC/IR.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i  in  1/1/ADDR_WIDTH/WIDTH  loader request; same meaning as m0.
- m1_lock_i  in  1  requests grant continuation (burst).
- m1_gnt_o, m1_rvalid_o, m1_rdata_o  out  1/1/WIDTH  same meaning as m0.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  WIDTH  memory write data.
- mem_rdata_i  in  WIDTH  memory read data.

Behaviour:
- Reset (rst=0, async): last_owner=1 so m0 wins the first tie; lock_cnt=0; read-tag pipeline cleared. All gnt/rvalid/mem strobes are 0 and core_stall_o=0 while in reset.
- Handshake:
  - Requester holds req/we/addr/wdata stable until gnt.
  - Grant is combinational in the cycle the request is selected; zero-cycle grant when uncontended.
  - Exactly one of m0_gnt_o/m1_gnt_o is high per cycle, or neither.
- Memory command: mem_read_o = gnt & ~we; mem_write_o = gnt & we. Address and wdata are muxed from the granted requester. Both are 0/hold-free when no grant, with address don't-care.
- FSM arb_state: IDLE, OWN0, OWN1. The state records the owner of the last grant.
  - IDLE -> OWNx on a grant.
  - OWNx -> IDLE on a cycle with no request.
- Selection: only one request pending -> grant it. Both pending -> grant the requester that is not last_owner, except:
  - If arb_state=OWN1, m1_lock_i=1 and lock_cnt<BURST_MAX, m1 keeps the grant.
- lock_cnt:
  - Increments on each m1 grant while m0_req_i=1.
  - Clears on any m0 grant, or when m1_lock_i=0.
  - At lock_cnt=BURST_MAX, m0 is granted next.
- Read return: each read grant pushes {valid, owner} into an RD_LAT-deep shift register. mX_rvalid_o = tail.valid & tail.owner==X. m0_rdata_o = m1_rdata_o = mem_rdata_i, unregistered.
- Writes complete in the grant cycle; no response beat.
- Back-to-back reads are allowed every cycle; reads from both owners may interleave in flight.
- core_stall_o = (m0_req_i & ~m0_gnt_o) | (m0 read in flight & ~m0_rvalid_o).
- A request on the same cycle a prior read returns is legal, with no bubble.
- Reset asserted mid-read: in-flight tags are discarded and no rvalid is emitted after reset release.

Decomposition:
- Add ARB_IDLE/ARB_OWN0/ARB_OWN1 state encodings and the OWNER_M0/OWNER_M1 tag constants to defines.v alongside `WIDTH`/`ADDR_WIDTH`.
- One natural sub-module: rd_tag_pipe, an RD_LAT-deep {valid, owner} shift register with async active-low clear.

Test Plan:
- Reset release, m0 read of addr 0x10 with mem returning 0xDEADBEEF: m0_gnt_o=1 and mem_read_o=1 in cycle 0; m0_rvalid_o=1 with 0xDEADBEEF in cycle RD_LAT; core_stall_o=1 only in cycles 1..RD_LAT-1 (0 cycles for RD_LAT=1).
- m0 and m1 both request reads in the same cycle after reset: m0 granted first, m1 next cycle. Rvalids return in the same order with the correct owners.
- m1 writes 0x100..0x10C with m1_lock_i=1 while m0 requests; BURST_MAX=4: m1 gets 4 grants, then m0 is granted in cycle 4; core_stall_o=1 in cycles 0..3.
- Alternating continuous requests with lock=0: grants strictly alternate m0, m1, m0, m1 over 8 cycles, and mem_write_o/mem_read_o follow each winner's we.
- RD_LAT=3 with interleaved reads m0@0x0, m1@0x4, m0@0x8: rvalids appear at cycles 3, 4, 5 routed m0, m1, m0.
- rst pulsed low one cycle after an m1 read grant: m1_rvalid_o is never asserted, and all outputs are 0 during reset.
